// File: rtl/spectrum_pkg.sv
// Shared sizing and write-FSM encoding for the spectrum frame writer.
package spectrum_pkg;

    localparam int DEPTH = 1024;
    localparam int DW    = 16;
    localparam int AW    = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ZERO  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } wr_state_t;

endpackage

// File: rtl/spectrum_bank_ram.sv
// One spectrum bank: simple dual-port RAM, synchronous write, registered read.
module spectrum_bank_ram
    import spectrum_pkg::*;
#(
    parameter int BANK_DEPTH = spectrum_pkg::DEPTH,
    parameter int BANK_DW    = spectrum_pkg::DW
) (
    input  logic               clk_pixel,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [BANK_DW-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [BANK_DW-1:0] rdata
);

    logic [BANK_DW-1:0] mem [BANK_DEPTH];

    always_ff @(posedge clk_pixel) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spectrum_frame_writer.sv
// Double-buffered spectrum frame store: FFT beats fill the hidden bank, the
// display reads the shown bank, and banks swap on a vsync falling edge once a frame is complete.
module spectrum_frame_writer
    import spectrum_pkg::*;
#(
    parameter int DEPTH = spectrum_pkg::DEPTH,
    parameter int DW    = spectrum_pkg::DW
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          vs_in,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          bank_sel,
    output logic          swap_pulse,
    output logic          overflow,
    input  logic          clr_status,
    output wr_state_t     state_dbg
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    wr_state_t     state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          vs_prev_q;
    logic          swap_evt;
    logic          accept;
    logic          ready_int;
    logic          wr_en;
    logic [AW-1:0] wr_waddr;
    logic [DW-1:0] wr_wdata;
    logic          set_ovf;
    logic          do_swap;

    // Handshake: a beat transfers on a rising clk_pixel edge where s_valid and
    // s_ready are both high; s_ready never depends on s_valid and is low in reset.
    assign swap_evt  = vs_prev_q & ~vs_in;
    assign accept    = s_valid & ready_int;
    assign s_ready   = ready_int & rst_n;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        ready_int = 1'b0;
        wr_en     = 1'b0;
        wr_waddr  = wr_addr_q + AW'(1);
        wr_wdata  = s_data;
        set_ovf   = 1'b0;
        do_swap   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_int = 1'b1;
                wr_waddr  = '0;
                if (accept) begin
                    wr_en     = 1'b1;
                    wr_addr_d = '0;
                    if (LAST_ADDR == '0) begin
                        if (s_last) begin
                            state_d = DONE;
                        end else begin
                            set_ovf = 1'b1;
                            state_d = DRAIN;
                        end
                    end else begin
                        state_d = s_last ? ZERO : FILL;
                    end
                end
            end
            FILL: begin
                ready_int = 1'b1;
                if (accept) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_waddr;
                    if (wr_waddr == LAST_ADDR) begin
                        if (s_last) begin
                            state_d = DONE;
                        end else begin
                            set_ovf = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_last) begin
                        state_d = ZERO;
                    end
                end
            end
            ZERO: begin
                // Short frame: blank the tail so stale bins never reach the display.
                wr_en     = 1'b1;
                wr_wdata  = '0;
                wr_addr_d = wr_waddr;
                if (wr_waddr == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                ready_int = 1'b1;
                if (accept && s_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (swap_evt) begin
                    do_swap   = 1'b1;
                    state_d   = IDLE;
                    wr_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            vs_prev_q  <= 1'b1;
            bank_sel   <= 1'b0;
            swap_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            vs_prev_q  <= vs_in;
            swap_pulse <= do_swap;
            if (do_swap) begin
                bank_sel <= ~bank_sel;
            end
            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
        end
    end

    logic [AW-1:0] rd_addr_q;
    logic          rd_sel_q, rd_sel_qq;
    logic [DW-1:0] q0, q1;

    // Bank choice travels with the address so a swap mid-read cannot mix banks.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rd_sel_q  <= 1'b0;
            rd_sel_qq <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_addr_q <= rd_addr;
            rd_sel_q  <= bank_sel;
            rd_sel_qq <= rd_sel_q;
            rd_data   <= rd_sel_qq ? q1 : q0;
        end
    end

    spectrum_bank_ram #(.BANK_DEPTH(DEPTH), .BANK_DW(DW)) u_bank0 (
        .clk_pixel (clk_pixel),
        .we        (wr_en & bank_sel),
        .waddr     (wr_waddr),
        .wdata     (wr_wdata),
        .raddr     (rd_addr_q),
        .rdata     (q0)
    );

    spectrum_bank_ram #(.BANK_DEPTH(DEPTH), .BANK_DW(DW)) u_bank1 (
        .clk_pixel (clk_pixel),
        .we        (wr_en & ~bank_sel),
        .waddr     (wr_waddr),
        .wdata     (wr_wdata),
        .raddr     (rd_addr_q),
        .rdata     (q1)
    );

endmodule

// File: tb/tb_spectrum_frame_writer.sv
// Bench for spectrum_frame_writer: random frames against a frame-level bank model,
// display reads checked through an expected-value queue.
module tb_spectrum_frame_writer;
    import spectrum_pkg::*;

    logic          clk_pixel;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          vs_in;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          bank_sel;
    logic          swap_pulse;
    logic          overflow;
    logic          clr_status;
    wr_state_t     state_dbg;

    int            checks;
    int            failures;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] bank_m [2][DEPTH];
    bit            bank_known [2];
    bit            model_sel;
    bit            model_ovf;
    logic [DW-1:0] beats [0:1199];
    int            swap_cnt;
    bit            bg_reads;
    logic          rd_req, req_d1, req_d2, req_d3;
    logic [AW-1:0] rd_a;
    logic [DW-1:0] e_v;

    spectrum_frame_writer dut (
        .clk_pixel  (clk_pixel),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .vs_in      (vs_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .bank_sel   (bank_sel),
        .swap_pulse (swap_pulse),
        .overflow   (overflow),
        .clr_status (clr_status),
        .state_dbg  (state_dbg)
    );

    // clock / watchdog
    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // scoreboard monitor: rd_data is due three edges after the request is driven
    always @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            req_d1 <= 1'b0;
            req_d2 <= 1'b0;
            req_d3 <= 1'b0;
        end else begin
            req_d1 <= rd_req;
            req_d2 <= req_d1;
            req_d3 <= req_d2;
        end
    end

    always @(negedge clk_pixel) begin
        if (swap_pulse === 1'b1) swap_cnt++;
        if (req_d3) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_data_unexpected actual=%0h expected=none", rd_data);
            end else begin
                e_v = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e_v));
            end
        end
    end

    // background random display reads of the shown bank
    initial begin
        forever begin
            @(posedge clk_pixel);
            #1;
            if (bg_reads) begin
                if (bank_known[model_sel]) begin
                    rd_a    = AW'($urandom_range(0, DEPTH - 1));
                    rd_addr = rd_a;
                    rd_req  = 1'b1;
                    exp_q.push_back(bank_m[model_sel][rd_a]);
                end else begin
                    rd_req = 1'b0;
                end
            end
        end
    end

    task automatic bg_stop();
        bg_reads = 1'b0;
        tick();
        rd_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic read_sweep();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            rd_req  = 1'b1;
            exp_q.push_back(bank_m[model_sel][a]);
            tick();
        end
        rd_req = 1'b0;
        repeat (4) tick();
    endtask

    // driver: one frame of n beats
    task automatic send_frame(input int n, input int last_idx, input int vs_fall_at,
                              input int clr_at, input bit idx_data, input bit gaps);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            beats[i]   = idx_data ? DW'(i) : DW'($urandom);
            s_data     = beats[i];
            s_valid    = 1'b1;
            s_last     = (i == last_idx);
            clr_status = (i == clr_at);
            if (vs_fall_at >= 0 && i == vs_fall_at) vs_in = 1'b0;
            if (vs_fall_at >= 0 && i == vs_fall_at + 10) vs_in = 1'b1;
            guard = 0;
            @(negedge clk_pixel);
            while (!s_ready && guard < 50) begin
                guard++;
                @(negedge clk_pixel);
            end
            if (guard >= 50) check("s_ready_stall", 32'(s_ready), 32'd1);
            tick();
            s_valid    = 1'b0;
            s_last     = 1'b0;
            clr_status = 1'b0;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        @(negedge clk_pixel);
        while (state_dbg != DONE && cyc < 3000) begin
            cyc++;
            @(negedge clk_pixel);
        end
        if (cyc >= 3000) check("wait_done_timeout", 32'(state_dbg), 32'(DONE));
    endtask

    // frame-level model: first DEPTH beats land in the hidden bank, the rest is zero
    task automatic model_commit(input int n);
        bit w;
        w = !model_sel;
        for (int i = 0; i < DEPTH; i++) bank_m[w][i] = (i < n) ? beats[i] : '0;
        bank_known[w] = 1'b1;
        if (n > DEPTH) model_ovf = 1'b1;
    endtask

    task automatic do_swap();
        int c0;
        bg_stop();
        vs_in = 1'b1;
        tick();
        tick();
        c0    = swap_cnt;
        vs_in = 1'b0;
        @(negedge clk_pixel);
        check("swap_pulse_pre", 32'(swap_pulse), 32'd0);
        @(negedge clk_pixel);
        model_sel = !model_sel;
        check("swap_pulse", 32'(swap_pulse), 32'd1);
        check("bank_sel_swap", 32'(bank_sel), 32'(model_sel));
        @(negedge clk_pixel);
        check("swap_pulse_one_cycle", 32'(swap_pulse), 32'd0);
        check("s_ready_after_swap", 32'(s_ready), 32'd1);
        tick();
        vs_in = 1'b1;
        tick();
        tick();
        check("swap_count", 32'(swap_cnt - c0), 32'd1);
    endtask

    initial begin
        int cyc;
        int c0;
        checks = 0; failures = 0; swap_cnt = 0;
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; vs_in = 1'b1;
        rd_addr = '0; clr_status = 1'b0; rd_req = 1'b0; bg_reads = 1'b0;
        model_sel = 1'b0; model_ovf = 1'b0;
        bank_known[0] = 1'b0; bank_known[1] = 1'b0;

        repeat (3) @(negedge clk_pixel);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_bank_sel", 32'(bank_sel), 32'd0);
        check("reset_swap_pulse", 32'(swap_pulse), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk_pixel);
        check("release_s_ready", 32'(s_ready), 32'd1);
        check("release_state", 32'(state_dbg), 32'(IDLE));
        tick();

        // full frame, value = index
        bg_reads = 1'b1;
        send_frame(1024, 1023, -1, -1, 1'b1, 1'b0);
        wait_done(cyc);
        check("zero_cycles_full", 32'(cyc), 32'd0);
        model_commit(1024);
        check("overflow_full", 32'(overflow), 32'(model_ovf));
        do_swap();
        read_sweep();

        // short frame: 724 zero-fill cycles
        bg_reads = 1'b1;
        send_frame(300, 299, -1, -1, 1'b0, 1'b1);
        wait_done(cyc);
        check("zero_cycles_short", 32'(cyc), 32'd724);
        check("s_ready_done", 32'(s_ready), 32'd0);
        model_commit(300);
        do_swap();
        read_sweep();

        // overflow frame; clear coincides with set on beat 1024
        bg_reads = 1'b1;
        send_frame(1100, 1099, -1, 1023, 1'b0, 1'b1);
        wait_done(cyc);
        check("zero_cycles_ovf", 32'(cyc), 32'd0);
        model_commit(1100);
        check("overflow_set", 32'(overflow), 32'(model_ovf));
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        model_ovf  = 1'b0;
        @(negedge clk_pixel);
        check("overflow_cleared", 32'(overflow), 32'(model_ovf));
        do_swap();
        read_sweep();

        // vsync falls mid-fill: ignored
        bg_reads = 1'b1;
        c0 = swap_cnt;
        send_frame(1050, 1049, 500, -1, 1'b0, 1'b1);
        wait_done(cyc);
        model_commit(1050);
        tick();
        tick();
        check("midfill_no_swap", 32'(swap_cnt - c0), 32'd0);
        check("midfill_bank_sel", 32'(bank_sel), 32'(model_sel));
        check("overflow_second", 32'(overflow), 32'(model_ovf));
        do_swap();

        // last beat coincides with vsync fall: swap waits for next fall
        bg_reads = 1'b1;
        c0 = swap_cnt;
        send_frame(500, 499, 499, -1, 1'b0, 1'b0);
        wait_done(cyc);
        check("zero_cycles_coincide", 32'(cyc), 32'd524);
        model_commit(500);
        repeat (5) tick();
        check("coincide_no_swap", 32'(swap_cnt - c0), 32'd0);
        check("coincide_bank_sel", 32'(bank_sel), 32'(model_sel));
        check("coincide_state", 32'(state_dbg), 32'(DONE));
        check("overflow_sticky", 32'(overflow), 32'(model_ovf));
        do_swap();

        // reset in the middle of a frame
        bg_reads = 1'b1;
        send_frame(400, -1, -1, -1, 1'b0, 1'b1);
        bg_stop();
        rst_n = 1'b0;
        for (int i = 0; i < 400; i++) bank_m[!model_sel][i] = beats[i];
        model_sel = 1'b0;
        model_ovf = 1'b0;
        @(negedge clk_pixel);
        check("midreset_s_ready", 32'(s_ready), 32'd0);
        check("midreset_bank_sel", 32'(bank_sel), 32'(model_sel));
        check("midreset_overflow", 32'(overflow), 32'(model_ovf));
        check("midreset_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk_pixel);
        check("midreset_release_ready", 32'(s_ready), 32'd1);
        check("midreset_release_state", 32'(state_dbg), 32'(IDLE));
        tick();
        read_sweep();

        // next frame must start at address 0
        bg_reads = 1'b1;
        send_frame(200, 199, -1, -1, 1'b0, 1'b1);
        wait_done(cyc);
        check("zero_cycles_after_reset", 32'(cyc), 32'd824);
        model_commit(200);
        do_swap();
        read_sweep();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
